// File: rtl/shift_add_multiplier_if.sv
// Start/ready/done handshake and operand/product bus of the shift-and-add multiplier.
// The master drives the operands and start; the slave returns status and the product.
interface shift_add_multiplier_if #(
  parameter int unsigned N = 8
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one partial product per clock, N iterations,
// then a one-cycle done pulse alongside a held 2N-bit product.
module shift_add_multiplier #(
  parameter int unsigned N = 8
) (
  input logic                   clk,
  input logic                   clr,
  shift_add_multiplier_if.slave bus
);
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_d;
  logic [CW-1:0]  count_q;
  logic [2*N-1:0] product_q;
  logic           done_q;

  // The final iteration's sum feeds the product register directly, saving a cycle.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q  <= {{N{1'b0}}, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == CALC);
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier at N=8 and N=4, with products
// predicted by plain integer multiplication and latencies from the fixed N-cycle schedule.
module tb_shift_add_multiplier;
  localparam int unsigned N8 = 8;
  localparam int unsigned N4 = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  shift_add_multiplier_if #(.N(N8)) bus8 ();
  shift_add_multiplier_if #(.N(N4)) bus4 ();

  shift_add_multiplier #(.N(N8)) dut8 (.clk(clk), .clr(clr), .bus(bus8));
  shift_add_multiplier #(.N(N4)) dut4 (.clk(clk), .clr(clr), .bus(bus4));

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] last8;
  logic [7:0]  last4;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one N=8 operation; poke injects junk inputs from that CALC cycle for 3 cycles,
  // abort_at asserts clr during that CALC cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int poke, input int abort_at);
    logic [15:0] exp;
    int lat, busy_cnt, done_cnt;
    bit seen;
    exp = 16'(a) * 16'(b);
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 1; k <= int'(N8) + 4 && !seen; k++) begin
      if (k >= poke && k < poke + 3) begin
        bus8.start = 1'b1;
        bus8.a = 8'd100;
        bus8.b = 8'd100;
      end else begin
        bus8.start = 1'b0;
      end
      if (k == abort_at) clr = 1'b1;
      if (bus8.busy) busy_cnt++;
      if (k == 2) chk("hold_in_calc", bus8.product, last8);
      tick();
      clr = 1'b0;
      if (k == abort_at) begin
        bus8.start = 1'b0;
        chk("abort_ready", {bus8.ready, bus8.busy, bus8.done}, 3'b100);
        chk("abort_product", bus8.product, 16'h0000);
        last8 = '0;
        done_cnt = 0;
        repeat (N8 + 2) begin
          tick();
          if (bus8.done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        return;
      end
      if (bus8.done) begin
        seen = 1'b1;
        lat = k;
      end
    end
    bus8.start = 1'b0;
    chk("latency8", lat, N8);
    chk("busy_cycles8", busy_cnt, N8);
    chk("product8", bus8.product, exp);
    last8 = exp;
    tick();
    chk("pulse_end8", {bus8.ready, bus8.busy, bus8.done}, 3'b100);
    chk("product_hold8", bus8.product, exp);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] exp;
    int lat;
    bit seen;
    exp = 8'(a) * 8'(b);
    bus4.a = a;
    bus4.b = b;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= int'(N4) + 4 && !seen; k++) begin
      if (k == 2) chk("hold_in_calc4", bus4.product, last4);
      tick();
      if (bus4.done) begin
        seen = 1'b1;
        lat = k;
      end
    end
    chk("latency4", lat, N4);
    chk("product4", bus4.product, exp);
    last4 = exp;
    tick();
    chk("pulse_end4", {bus4.ready, bus4.busy, bus4.done}, 3'b100);
  endtask

  initial begin
    clr = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    last8 = '0;
    last4 = '0;
    tick();
    tick();
    clr = 1'b0;
    tick();
    chk("reset_status8", {bus8.ready, bus8.busy, bus8.done}, 3'b100);
    chk("reset_product8", bus8.product, 16'h0000);
    chk("reset_status4", {bus4.ready, bus4.busy, bus4.done}, 3'b100);
    chk("reset_product4", bus4.product, 8'h00);

    op8(8'd13, 8'd11, 100, 100);
    chk("known_13x11", last8, 16'h008F);
    op8(8'd255, 8'd255, 100, 100);
    op8(8'd0, 8'd200, 100, 100);
    op8(8'd3, 8'd5, 3, 100);
    chk("ignored_start", bus8.product, 16'h000F);
    op8(8'd200, 8'd7, 100, 4);

    bus8.a = 8'd9;
    bus8.b = 8'd9;
    bus8.start = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus8.start = 1'b0;
    chk("clr_beats_start", {bus8.ready, bus8.busy, bus8.done}, 3'b100);
    tick();
    chk("stays_idle", {bus8.ready, bus8.busy, bus8.done}, 3'b100);
    chk("stays_idle_product", bus8.product, 16'h0000);

    for (int i = 0; i < 50; i++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 100, 100);

    op4(4'd15, 4'd15);
    chk("known_15x15", bus4.product, 8'hE1);
    for (int i = 0; i < 20; i++)
      op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
